// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter and its picker.
package uart_arb_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2,
        HOLD      = 2'd3
    } arb_state_t;

    // Ceiling log2, used to size index buses (returns 0 for values 0 and 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request bit strictly after
// i_Last, wrapping modulo NUM_REQ.
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_Req,
    input  logic [IDX_W-1:0]   i_Last,
    output logic               o_Found,
    output logic [IDX_W-1:0]   o_Idx
);

    int unsigned pos;

    // Scan from farthest to nearest candidate so the nearest set bit is the last assignment.
    always_comb begin
        o_Found = 1'b0;
        o_Idx   = '0;
        pos     = 0;
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            pos = (32'(i_Last) + i) % NUM_REQ;
            if (i_Req[pos[IDX_W-1:0]]) begin
                o_Found = 1'b1;
                o_Idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte sources.
// Optional frame lock enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                      i_Clock,
    input  logic                      i_Rst_L,
    input  logic [NUM_REQ-1:0]        i_Req_DV,
    input  logic [NUM_REQ*BYTE_W-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]        i_Req_Last,
    output logic [NUM_REQ-1:0]        o_Req_Ack,
    output logic [NUM_REQ-1:0]        o_Req_Done,
    output logic                      o_TX_DV,
    output logic [BYTE_W-1:0]         o_TX_Byte,
    input  logic                      i_TX_Active,
    input  logic                      i_TX_Done,
    output logic                      o_Busy,
    output logic [IDX_W-1:0]          o_Grant_Idx
);

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    arb_state_t          r_State;
    arb_state_t          w_State_Nxt;
    logic [IDX_W-1:0]    r_Last;
    logic [NUM_REQ-1:0]  w_Elig;
    logic                w_Found;
    logic [IDX_W-1:0]    w_Win;
    logic                w_Launch;
    logic                w_Finish;
    logic [BYTE_W-1:0]   w_Req_Bytes [NUM_REQ];

    logic [NUM_REQ-1:0]  w_Ack_Nxt;
    logic [NUM_REQ-1:0]  w_Done_Nxt;
    logic                w_TX_DV_Nxt;
    logic [BYTE_W-1:0]   w_TX_Byte_Nxt;
    logic                w_Busy_Nxt;
    logic [IDX_W-1:0]    w_Grant_Nxt;
    logic [IDX_W-1:0]    w_Last_Nxt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_Req_Bytes[g] = i_Req_Byte[g*BYTE_W +: BYTE_W];
    end

`ifdef UART_ARB_LOCK_EN
    logic r_Frame_Last;

    // Latch the frame-end flag of the byte being accepted; reset value releases any lock.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            r_Frame_Last <= 1'b1;
        end else if (w_Launch) begin
            r_Frame_Last <= i_Req_Last[w_Win];
        end
    end
`else
    logic unused_req_last;
    assign unused_req_last = ^i_Req_Last;
`endif

    // Eligible requesters: everyone in IDLE, only the locked owner in HOLD.
    always_comb begin
        w_Elig = '0;
        case (r_State)
            IDLE:    w_Elig = i_Req_DV;
`ifdef UART_ARB_LOCK_EN
            HOLD:    w_Elig = i_Req_DV & (NUM_REQ'(1) << o_Grant_Idx);
`endif
            default: w_Elig = '0;
        endcase
    end

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_Req   (w_Elig),
        .i_Last  (r_Last),
        .o_Found (w_Found),
        .o_Idx   (w_Win)
    );

    // UART_TX may still be shifting out a frame aborted by our reset.
    assign w_Launch = w_Found & ~i_TX_Active;
    assign w_Finish = (r_State == WAIT_DONE) & i_TX_Done;

    // State and registered outputs.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            r_State     <= IDLE;
            r_Last      <= LAST_RST;
            o_Req_Ack   <= '0;
            o_Req_Done  <= '0;
            o_TX_DV     <= 1'b0;
            o_TX_Byte   <= '0;
            o_Busy      <= 1'b0;
            o_Grant_Idx <= LAST_RST;
        end else begin
            r_State     <= w_State_Nxt;
            r_Last      <= w_Last_Nxt;
            o_Req_Ack   <= w_Ack_Nxt;
            o_Req_Done  <= w_Done_Nxt;
            o_TX_DV     <= w_TX_DV_Nxt;
            o_TX_Byte   <= w_TX_Byte_Nxt;
            o_Busy      <= w_Busy_Nxt;
            o_Grant_Idx <= w_Grant_Nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_State_Nxt = r_State;
        case (r_State)
            IDLE: begin
                if (w_Launch) w_State_Nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_TX_Done) w_State_Nxt = GAP;
            end
            GAP: begin
`ifdef UART_ARB_LOCK_EN
                w_State_Nxt = r_Frame_Last ? IDLE : HOLD;
`else
                w_State_Nxt = IDLE;
`endif
            end
`ifdef UART_ARB_LOCK_EN
            HOLD: begin
                if (w_Launch) w_State_Nxt = WAIT_DONE;
            end
`endif
            default: w_State_Nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and round-robin pointer.
    always_comb begin
        w_Ack_Nxt     = '0;
        w_Done_Nxt    = '0;
        w_TX_DV_Nxt   = 1'b0;
        w_TX_Byte_Nxt = o_TX_Byte;
        w_Grant_Nxt   = o_Grant_Idx;
        w_Last_Nxt    = r_Last;
        w_Busy_Nxt    = (w_State_Nxt != IDLE);
        if (w_Launch) begin
            w_Ack_Nxt     = NUM_REQ'(1) << w_Win;
            w_TX_DV_Nxt   = 1'b1;
            w_TX_Byte_Nxt = w_Req_Bytes[w_Win];
            w_Grant_Nxt   = w_Win;
        end
        if (w_Finish) begin
            w_Done_Nxt = NUM_REQ'(1) << o_Grant_Idx;
            w_Last_Nxt = o_Grant_Idx;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (NUM_REQ=4); the bench
// plays the part of UART_TX by driving i_TX_Active / i_TX_Done directly.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic [3:0]  req_dv = '0;
    logic [31:0] req_byte = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ack;
    logic [3:0]  req_done;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic        busy;
    logic [1:0]  grant;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ (4),
        .IDX_W   (2)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_l),
        .i_Req_DV    (req_dv),
        .i_Req_Byte  (req_byte),
        .i_Req_Last  (req_last),
        .o_Req_Ack   (req_ack),
        .o_Req_Done  (req_done),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .i_TX_Active (tx_active),
        .i_TX_Done   (tx_done),
        .o_Busy      (busy),
        .o_Grant_Idx (grant)
    );

    // One row = inputs held for one cycle, outputs expected after that edge.
    typedef struct {
        string       tag;
        logic        rst_l;
        logic [3:0]  dv;
        logic [31:0] bytes;
        logic [3:0]  last;
        logic        act;
        logic        done;
        logic [3:0]  e_ack;
        logic [3:0]  e_done;
        logic        e_dv;
        logic [7:0]  e_byte;
        logic        e_busy;
        logic [1:0]  e_grant;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string tag, input logic r, input logic [3:0] dv,
                       input logic [31:0] b, input logic [3:0] l, input logic a,
                       input logic d, input logic [3:0] eack, input logic [3:0] edone,
                       input logic edv, input logic [7:0] ebyte, input logic ebusy,
                       input logic [1:0] egrant);
        vec_t v;
        v.tag = tag; v.rst_l = r; v.dv = dv; v.bytes = b; v.last = l;
        v.act = a; v.done = d; v.e_ack = eack; v.e_done = edone; v.e_dv = edv;
        v.e_byte = ebyte; v.e_busy = ebusy; v.e_grant = egrant;
        vecs.push_back(v);
    endtask

    task automatic add_reset(input string tag);
        add(tag, 1'b0, 4'hF, 32'hA3A2A1A0, 4'hF, 1'b0, 1'b1,
            4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd3);
    endtask

    task automatic add_idle(input string tag, input logic [7:0] eb, input logic [1:0] eg);
        add(tag, 1'b1, 4'h0, 32'h0, 4'hF, 1'b0, 1'b0,
            4'h0, 4'h0, 1'b0, eb, 1'b0, eg);
    endtask

    // Launch cycle, UART active cycle, done cycle, GAP cycle.
    task automatic add_xfer(input string tag, input logic [3:0] dv, input logic [31:0] b,
                            input logic [3:0] l, input int k, input logic [7:0] eb,
                            input logic gap_busy);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        add(tag, 1'b1, dv, b, l, 1'b0, 1'b0, oh,   4'h0, 1'b1, eb, 1'b1,     2'(k));
        add(tag, 1'b1, dv, b, l, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, eb, 1'b1,     2'(k));
        add(tag, 1'b1, dv, b, l, 1'b0, 1'b1, 4'h0, oh,   1'b0, eb, 1'b1,     2'(k));
        add(tag, 1'b1, dv, b, l, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, eb, gap_busy, 2'(k));
    endtask

    task automatic check(input string tag, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0h expected=%0h at %0t", tag, field, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        rst_l     = v.rst_l;
        req_dv    = v.dv;
        req_byte  = v.bytes;
        req_last  = v.last;
        tx_active = v.act;
        tx_done   = v.done;
        @(posedge clk);
        #1;
        check(v.tag, "ack",   32'(req_ack),  32'(v.e_ack));
        check(v.tag, "done",  32'(req_done), 32'(v.e_done));
        check(v.tag, "tx_dv", 32'(tx_dv),    32'(v.e_dv));
        check(v.tag, "byte",  32'(tx_byte),  32'(v.e_byte));
        check(v.tag, "busy",  32'(busy),     32'(v.e_busy));
        check(v.tag, "grant", 32'(grant),    32'(v.e_grant));
    endtask

    task automatic run_table;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
        vecs.delete();
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};

        // Reset values, then a single request from requester 0.
        add_reset("rst");
        add_reset("rst");
        add_xfer("single", 4'b0001, 32'h0000003F, 4'hF, 0, 8'h3F, 1'b0);
        add_idle("single_idle", 8'h3F, 2'd0);
        add_idle("single_idle", 8'h3F, 2'd0);

        // Fairness: all four held valid from reset.
        add_reset("fair_rst");
        for (int i = 0; i < 5; i++)
            add_xfer("fair", 4'hF, 32'hA3A2A1A0, 4'hF, order[i], 8'hA0 + 8'(order[i]), 1'b0);
        add_idle("fair_idle", 8'hA0, 2'd0);

        // Wrap-around from pointer 3 with requesters 1 and 3 only.
        add_reset("wrap_rst");
        add_xfer("wrap", 4'b1010, 32'hA3A2A1A0, 4'hF, 1, 8'hA1, 1'b0);
        add_xfer("wrap", 4'b1010, 32'hA3A2A1A0, 4'hF, 3, 8'hA3, 1'b0);
        add_xfer("wrap", 4'b1010, 32'hA3A2A1A0, 4'hF, 1, 8'hA1, 1'b0);
        add_idle("wrap_idle", 8'hA1, 2'd1);

        // Withdrawal while UART busy, then a stray done in IDLE.
        add("withdraw", 1'b1, 4'b0100, 32'hA3A2A1A0, 4'hF, 1'b1, 1'b0,
            4'h0, 4'h0, 1'b0, 8'hA1, 1'b0, 2'd1);
        add("withdraw", 1'b1, 4'b0000, 32'hA3A2A1A0, 4'hF, 1'b0, 1'b0,
            4'h0, 4'h0, 1'b0, 8'hA1, 1'b0, 2'd1);
        add("stray_done", 1'b1, 4'b0000, 32'h0, 4'hF, 1'b0, 1'b1,
            4'h0, 4'h0, 1'b0, 8'hA1, 1'b0, 2'd1);
        add_idle("stray_idle", 8'hA1, 2'd1);
        run_table();

        // Reset in the middle of a frame with requester 1 pending.
        add("midrst_go",  1'b1, 4'b0001, 32'h00002211, 4'hF, 1'b0, 1'b0,
            4'b0001, 4'h0, 1'b1, 8'h11, 1'b1, 2'd0);
        add("midrst_act", 1'b1, 4'b0010, 32'h00002211, 4'hF, 1'b1, 1'b0,
            4'h0, 4'h0, 1'b0, 8'h11, 1'b1, 2'd0);
        add("midrst_rst", 1'b0, 4'b0010, 32'h00002211, 4'hF, 1'b1, 1'b0,
            4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd3);
        add("midrst_blk", 1'b1, 4'b0011, 32'h00002211, 4'hF, 1'b1, 1'b0,
            4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd3);
        add("midrst_blk", 1'b1, 4'b0011, 32'h00002211, 4'hF, 1'b1, 1'b0,
            4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd3);
        add("midrst_res", 1'b1, 4'b0011, 32'h00002211, 4'hF, 1'b0, 1'b1,
            4'b0001, 4'h0, 1'b1, 8'h11, 1'b1, 2'd0);
        add("midrst_act", 1'b1, 4'b0011, 32'h00002211, 4'hF, 1'b1, 1'b0,
            4'h0, 4'h0, 1'b0, 8'h11, 1'b1, 2'd0);
        add("midrst_dn",  1'b1, 4'b0011, 32'h00002211, 4'hF, 1'b0, 1'b1,
            4'h0, 4'b0001, 1'b0, 8'h11, 1'b1, 2'd0);
        add("midrst_gap", 1'b1, 4'b0011, 32'h00002211, 4'hF, 1'b0, 1'b0,
            4'h0, 4'h0, 1'b0, 8'h11, 1'b0, 2'd0);
        add_xfer("midrst_r1", 4'b0010, 32'h00002211, 4'hF, 1, 8'h22, 1'b0);
        add_idle("midrst_idle", 8'h22, 2'd1);
        run_table();

        // Frame lock: requester 0 sends 10,11,12 (Last on 12) while requester 1 waits.
        add_reset("lock_rst");
`ifdef UART_ARB_LOCK_EN
        add_xfer("lock", 4'b0011, 32'h0000B110, 4'b0010, 0, 8'h10, 1'b1);
        add_xfer("lock", 4'b0011, 32'h0000B111, 4'b0010, 0, 8'h11, 1'b1);
        add_xfer("lock", 4'b0011, 32'h0000B112, 4'b0011, 0, 8'h12, 1'b0);
        add_xfer("lock", 4'b0010, 32'h0000B112, 4'b0011, 1, 8'hB1, 1'b0);
        add_idle("lock_idle", 8'hB1, 2'd1);
`else
        add_xfer("nolock", 4'b0011, 32'h0000B110, 4'b0010, 0, 8'h10, 1'b0);
        add_xfer("nolock", 4'b0011, 32'h0000B111, 4'b0010, 1, 8'hB1, 1'b0);
        add_xfer("nolock", 4'b0011, 32'h0000B111, 4'b0010, 0, 8'h11, 1'b0);
        add_xfer("nolock", 4'b0011, 32'h0000B112, 4'b0011, 1, 8'hB1, 1'b0);
        add_xfer("nolock", 4'b0011, 32'h0000B112, 4'b0011, 0, 8'h12, 1'b0);
        add_idle("nolock_idle", 8'h12, 2'd0);
`endif
        run_table();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART_TX byte transmitter among NUM_REQ independent byte sources using round-robin arbitration.
- Each source presents a byte with a valid/ack handshake. The arbiter launches exactly one UART_TX transfer at a time and returns a per-source completion pulse.
- Sits between the command/response producers and the UART_TX instance. Its o_TX_* outputs drive UART_TX inputs directly.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- IDX_W, 2, width of the grant index; must equal clog2(NUM_REQ).

Ports:
- i_Clock  in  1  system clock; all logic on the rising edge.
- i_Rst_L  in  1  synchronous reset, active-low.
- i_Req_DV  in  NUM_REQ  per-requester byte valid.
- i_Req_Byte  in  NUM_REQ*8  flattened bytes; requester k uses bits [8k+7:8k].
- i_Req_Last  in  NUM_REQ  last byte of frame; used only with UART_ARB_LOCK_EN.
- o_Req_Ack  out  NUM_REQ  one-cycle pulse: byte of requester k accepted.
- o_Req_Done  out  NUM_REQ  one-cycle pulse: byte of requester k fully transmitted.
- o_TX_DV  out  1  one-cycle launch pulse to UART_TX.
- o_TX_Byte  out  8  byte to UART_TX; held stable until done.
- i_TX_Active  in  1  from UART_TX o_TX_Active.
- i_TX_Done  in  1  from UART_TX o_TX_Done (one-cycle pulse).
- o_Busy  out  1  high in every state except IDLE.
- o_Grant_Idx  out  IDX_W  index of the current or most recent grant.

Behaviour:
- All outputs are registered.
- Reset values: o_Req_Ack=0, o_Req_Done=0, o_TX_DV=0, o_TX_Byte=0, o_Busy=0, o_Grant_Idx=NUM_REQ-1. Round-robin pointer r_Last=NUM_REQ-1, so requester 0 wins first. State=IDLE.
- FSM states: IDLE, WAIT_DONE, GAP (plus HOLD with the macro).
- IDLE:
  - Arbitrates only when at least one i_Req_DV bit is high and i_TX_Active=0.
  - Winner k is the first set bit searched from r_Last+1 upward, wrapping modulo NUM_REQ.
  - At the next edge: o_Req_Ack[k]=1, o_TX_DV=1, o_TX_Byte=byte k, o_Grant_Idx=k, o_Busy=1, state goes to WAIT_DONE.
  - Latency: request seen in cycle N gives ack and launch in cycle N+1.
- WAIT_DONE:
  - o_Req_Ack and o_TX_DV drop after one cycle.
  - Waits indefinitely for i_TX_Done.
  - On i_TX_Done: at the next edge o_Req_Done[k]=1, r_Last=k, state goes to GAP.
- GAP: one cycle, lets UART_TX finish its cleanup; then state goes to IDLE.
- Back-to-back bytes from different requesters are therefore separated by at least 2 idle cycles after i_TX_Done.
- Requester rule: hold i_Req_DV and byte stable until o_Req_Ack is seen. It may change or drop them in the ack cycle.
- Requests are sampled only in IDLE. i_Req_DV deasserted before ack is a withdrawal, not an error.
- i_TX_Done outside WAIT_DONE is ignored.
- Reset mid-transfer:
  - All outputs and the pointer return to reset values at the next edge.
  - UART_TX is not reset by this block, so the IDLE guard (i_TX_Active=0) blocks a new launch until the in-flight frame ends.
  - No o_Req_Done is issued for the aborted byte.
- Only one bit of o_Req_Ack or o_Req_Done is ever high (one-hot or zero).

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- With the macro (frame lock):
  - After i_TX_Done, if i_Req_Last[k] was 0 when byte k was accepted (latched at ack), state goes from GAP to HOLD instead of IDLE.
  - In HOLD only requester k is eligible, subject to the same i_TX_Active=0 guard. Its next byte is launched exactly as from IDLE.
  - The lock releases when a byte with Last=1 completes, or on reset.
- Without the macro: i_Req_Last is ignored and HOLD does not exist.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum constants IDLE/WAIT_DONE/GAP/HOLD (2 bits);
  - a clog2 function;
  - BYTE_W=8.
- One combinational sub-module, uart_rr_picker:
  - inputs: request vector and r_Last;
  - outputs: found flag and winner index;
  - reusable by other arbiters.

Test Plan:
- Single request: req0 DV with 8'h3F. Ack[0] and TX_DV one cycle later; UART_TX line carries 8'h3F; Done[0] pulse one cycle after i_TX_Done; o_Busy low 2 cycles after i_TX_Done.
- Fairness: all four requesters held valid (8'hA0..8'hA3). Grant order 0,1,2,3,0. Each Done precedes the next Ack by at least 2 cycles.
- Wrap-around: r_Last=3, requests on 1 and 3 only. Grant goes to 1, then 3.
- Withdrawal and ignore: req2 DV drops before arbitration, so no ack. A stray i_TX_Done in IDLE produces no Done pulse.
- Reset mid-frame: assert i_Rst_L=0 for one cycle during the data bits, with req1 pending. Outputs clear at once; no launch until i_TX_Active falls; then req0-priority order resumes.
- UART_ARB_LOCK_EN: req0 sends 3 bytes (Last=0,0,1) while req1 is valid. Req1 is granted only after req0's Last byte; without the macro, grants interleave 0,1,0,...
